// File: rtl/status_register_unit.sv
// NZCV status producer: flag generation, zero-latency forwarding,
// committed status register and a one-entry saved-status copy.
module status_register_unit #(
    parameter int          WIDTH       = 32,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exe_valid,
    input  logic             s_bit,
    input  logic [2:0]       flag_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] logic_result,
    input  logic             shifter_carry,
    input  logic             stall,
    input  logic             flush,
    input  logic             save_req,
    input  logic             restore_req,
    output logic [3:0]       Status_Register,
    output logic [3:0]       status_fwd,
    output logic [3:0]       saved_status,
    output logic             flags_written
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOGIC = 3'b001,
        OP_ADD   = 3'b010,
        OP_ADC   = 3'b011,
        OP_SUB   = 3'b100,
        OP_SBC   = 3'b101,
        OP_RSB   = 3'b110,
        OP_HOLD7 = 3'b111
    } flag_op_t;

    flag_op_t         op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             is_arith;
    logic             is_logic;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_new;
    logic             v_new;
    logic [3:0]       new_flags;
    logic             commit;
    logic             restore_en;
    logic             save_en;
    logic [3:0]       save_val;
    logic             cur_c;

    assign op    = flag_op_t'(flag_op);
    assign cur_c = Status_Register[2];

    // Operand steering: subtracts feed the inverted operand into the adder
    always_comb begin
        x        = op_a;
        y        = op_b;
        cin      = 1'b0;
        is_arith = 1'b0;
        is_logic = 1'b0;
        unique case (op)
            OP_LOGIC: is_logic = 1'b1;
            OP_ADD: begin
                is_arith = 1'b1;
            end
            OP_ADC: begin
                is_arith = 1'b1;
                cin      = cur_c;
            end
            OP_SUB: begin
                is_arith = 1'b1;
                y        = ~op_b;
                cin      = 1'b1;
            end
            OP_SBC: begin
                is_arith = 1'b1;
                y        = ~op_b;
                cin      = cur_c;
            end
            OP_RSB: begin
                is_arith = 1'b1;
                x        = op_b;
                y        = ~op_a;
                cin      = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    assign res   = is_logic ? logic_result : sum[WIDTH-1:0];
    assign c_new = is_logic ? shifter_carry : sum[WIDTH];
    assign v_new = is_logic ? Status_Register[0]
                 : (x[WIDTH-1] == y[WIDTH-1]) &
                   (res[WIDTH-1] != x[WIDTH-1]);

    assign new_flags = {(res == '0), c_new, res[WIDTH-1], v_new};

    assign commit = exe_valid & s_bit & ~flush & ~stall &
                    (is_arith | is_logic);

    assign restore_en = restore_req & ~stall;
    assign save_en    = save_req & ~stall;

    // Restore beats a same-cycle commit
    always_comb begin
        status_fwd = Status_Register;
        if (restore_en)
            status_fwd = saved_status;
        else if (commit)
            status_fwd = new_flags;
    end

    // Save alongside restore swaps the two registers
    assign save_val = restore_en ? Status_Register : status_fwd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            Status_Register <= RESET_FLAGS;
            saved_status    <= RESET_FLAGS;
            flags_written   <= 1'b0;
        end else begin
            Status_Register <= status_fwd;
            if (save_en)
                saved_status <= save_val;
            flags_written <= commit | restore_en;
        end
    end

endmodule

// File: tb/tb_status_register_unit.sv
// Bench for status_register_unit: directed literal checks followed by
// randomized traffic compared every cycle against an arithmetic model.
module tb_status_register_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         exe_valid;
    logic         s_bit;
    logic [2:0]   flag_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] logic_result;
    logic         shifter_carry;
    logic         stall;
    logic         flush;
    logic         save_req;
    logic         restore_req;
    logic [3:0]   Status_Register;
    logic [3:0]   status_fwd;
    logic [3:0]   saved_status;
    logic         flags_written;

    int errors = 0;
    int checks = 0;

    status_register_unit #(.WIDTH(W), .RESET_FLAGS(4'b0000)) dut (
        .clk(clk),
        .rst(rst),
        .exe_valid(exe_valid),
        .s_bit(s_bit),
        .flag_op(flag_op),
        .op_a(op_a),
        .op_b(op_b),
        .logic_result(logic_result),
        .shifter_carry(shifter_carry),
        .stall(stall),
        .flush(flush),
        .save_req(save_req),
        .restore_req(restore_req),
        .Status_Register(Status_Register),
        .status_fwd(status_fwd),
        .saved_status(saved_status),
        .flags_written(flags_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference flags from plain signed/unsigned arithmetic
    function automatic logic [3:0] model_flags(
        input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] lr, input logic sc, input logic [3:0] cur);
        longint unsigned ua, ub, ures, two32;
        longint          sa, sb, sres, borrow;
        logic [31:0]     r;
        logic            c, v;
        ua = a;
        ub = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        two32 = 64'h1_0000_0000;
        borrow = cur[2] ? 0 : 1;
        ures = 0;
        sres = 0;
        case (op)
            3'd2: begin ures = ua + ub; sres = sa + sb; end
            3'd3: begin
                ures = ua + ub + (cur[2] ? 1 : 0);
                sres = sa + sb + (cur[2] ? 1 : 0);
            end
            3'd4: begin ures = ua - ub + two32; sres = sa - sb; end
            3'd5: begin
                ures = ua - ub - longint'(borrow) + two32;
                sres = sa - sb - borrow;
            end
            3'd6: begin ures = ub - ua + two32; sres = sb - sa; end
            default: ;
        endcase
        if (op == 3'd1) begin
            r = lr;
            c = sc;
            v = cur[0];
        end else begin
            r = ures[31:0];
            c = ures[32];
            v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        end
        return {(r == 32'd0), c, r[31], v};
    endfunction

    logic [3:0] m_sr, m_sv;
    logic       m_fw;
    bit         m_valid = 0;

    function automatic bit m_commit();
        return exe_valid && s_bit && !flush && !stall &&
               flag_op != 3'd0 && flag_op != 3'd7;
    endfunction

    function automatic logic [3:0] m_fwd();
        if (restore_req && !stall) return m_sv;
        if (m_commit())
            return model_flags(flag_op, op_a, op_b, logic_result,
                               shifter_carry, m_sr);
        return m_sr;
    endfunction

    always @(posedge clk) begin
        logic [3:0] f;
        logic [3:0] old_sr;
        bit         rs;
        if (!rst) begin
            m_sr = 4'b0000;
            m_sv = 4'b0000;
            m_fw = 1'b0;
            m_valid = 1;
        end else begin
            f      = m_fwd();
            old_sr = m_sr;
            rs     = restore_req && !stall;
            if (save_req && !stall) m_sv = rs ? old_sr : f;
            m_fw = m_commit() || rs;
            m_sr = f;
        end
    end

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_sr", Status_Register, m_sr);
            chk("cyc_saved", saved_status, m_sv);
            chk("cyc_fw", {3'b000, flags_written}, {3'b000, m_fw});
            chk("cyc_fwd", status_fwd, m_fwd());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_valid = 1'b0;
        s_bit = 1'b0;
        flag_op = 3'd0;
        op_a = '0;
        op_b = '0;
        logic_result = '0;
        shifter_carry = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        save_req = 1'b0;
        restore_req = 1'b0;
    endtask

    task automatic instr(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
        exe_valid = 1'b1;
        s_bit = s;
        flag_op = op;
        op_a = a;
        op_b = b;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        instr(3'd2, 32'd5, 32'd3, 1'b0);
        #1 chk("nos_fwd", status_fwd, 4'b0000);
        step();
        chk("nos_sr", Status_Register, 4'b0000);
        chk("nos_fw", {3'b0, flags_written}, 4'b0000);

        instr(3'd4, 32'd5, 32'd5, 1'b1);
        #1 chk("sub_eq_fwd", status_fwd, 4'b1100);
        step();
        chk("sub_eq_sr", Status_Register, 4'b1100);
        chk("sub_eq_fw", {3'b0, flags_written}, 4'b0001);
        idle();
        step();
        chk("fw_pulse", {3'b0, flags_written}, 4'b0000);

        instr(3'd2, 32'h7FFF_FFFF, 32'd1, 1'b1);
        step();
        chk("add_ovf", Status_Register, 4'b0011);
        instr(3'd3, 32'hFFFF_FFFF, 32'd0, 1'b1);
        step();
        chk("adc_c0", Status_Register, 4'b0010);
        instr(3'd2, 32'hFFFF_FFFF, 32'd1, 1'b1);
        #1 chk("add_wrap_fwd", status_fwd, 4'b1100);
        instr(3'd2, 32'h7FFF_FFFF, 32'd1, 1'b1);
        step();
        chk("add_ovf2", Status_Register, 4'b0011);

        instr(3'd1, 32'd0, 32'd0, 1'b1);
        logic_result = 32'd0;
        shifter_carry = 1'b1;
        flush = 1'b1;
        step();
        chk("logic_flush", Status_Register, 4'b0011);
        chk("logic_flush_fw", {3'b0, flags_written}, 4'b0000);
        flush = 1'b0;
        stall = 1'b1;
        step();
        chk("logic_stall", Status_Register, 4'b0011);
        chk("logic_stall_fw", {3'b0, flags_written}, 4'b0000);
        stall = 1'b0;
        step();
        chk("logic_sr", Status_Register, 4'b1101);

        idle();
        instr(3'd4, 32'd5, 32'd5, 1'b1);
        step();
        idle();
        save_req = 1'b1;
        step();
        chk("save", saved_status, 4'b1100);
        save_req = 1'b0;
        instr(3'd4, 32'd5, 32'd3, 1'b1);
        step();
        chk("sub_53", Status_Register, 4'b0100);
        idle();
        restore_req = 1'b1;
        step();
        chk("restore", Status_Register, 4'b1100);
        instr(3'd4, 32'd5, 32'd3, 1'b1);
        step();
        chk("restore_wins", Status_Register, 4'b1100);
        chk("restore_fw", {3'b0, flags_written}, 4'b0001);
        restore_req = 1'b0;
        step();
        chk("sub_53b", Status_Register, 4'b0100);
        idle();
        save_req = 1'b1;
        restore_req = 1'b1;
        step();
        chk("swap_sr", Status_Register, 4'b1100);
        chk("swap_saved", saved_status, 4'b0100);
        save_req = 1'b0;
        rst = 1'b0;
        step();
        chk("rst_sr", Status_Register, 4'b0000);
        chk("rst_saved", saved_status, 4'b0000);
        rst = 1'b1;
        idle();

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            exe_valid = ($urandom_range(0, 9) < 8);
            s_bit = ($urandom_range(0, 9) < 7);
            flag_op = 3'($urandom_range(0, 7));
            op_a = pick();
            op_b = pick();
            logic_result = pick();
            shifter_carry = 1'($urandom);
            stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 15);
            save_req = ($urandom_range(0, 9) < 1);
            restore_req = ($urandom_range(0, 9) < 1);
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
